// File: rtl/pc_sequencer.sv
// Fetch program counter with a prioritised redirect mux, a circular return-address
// stack and a BOOT/RUN/HALT state machine that gates fetch requests.
module pc_sequencer #(
  parameter int                ADDR_W    = 10,
  parameter int                ISSUE_W   = 2,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flush_valid,
  input  logic [ADDR_W-1:0]                flush_pc,
  input  logic                             branch_valid,
  input  logic                             branch_call,
  input  logic                             branch_ret,
  input  logic [ADDR_W-1:0]                branch_target,
  input  logic                             halt_req,
  input  logic                             resume,
  output logic [ADDR_W-1:0]                pc_out,
  output logic                             pc_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       pc_nxt;
  logic [ADDR_W-1:0]       pc_inc;
  logic [ADDR_W-1:0]       ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, wr_ptr_inc, top_ptr;
  logic                    push, pop, set_ovf, set_unf;
  logic                    ras_full;

  // Clears the sub-group bits so every fetch address lands on an issue-group boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] mask;
    mask = ~(ADDR_W'(ISSUE_W - 1));
    return a & mask;
  endfunction

  assign pc_inc     = pc_out + ADDR_W'(ISSUE_W);
  assign ras_full   = (ras_count == CNT_W'(RAS_DEPTH));
  assign wr_ptr_inc = (wr_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign top_ptr    = (wr_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : wr_ptr - 1'b1;
  assign pc_valid   = (state == RUN);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (flush_valid) begin
          pc_nxt = align_pc(flush_pc);
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (stall) begin
          pc_nxt = pc_out;
        end else if (branch_ret) begin
          if (ras_count != '0) begin
            pc_nxt = ras_mem[top_ptr];
            pop    = 1'b1;
          end else begin
            pc_nxt  = align_pc(branch_target);
            set_unf = 1'b1;
          end
        end else if (branch_valid && branch_call) begin
          push    = 1'b1;
          set_ovf = ras_full;
          pc_nxt  = align_pc(branch_target);
        end else if (branch_valid) begin
          pc_nxt = align_pc(branch_target);
        end else begin
          pc_nxt = pc_inc;
        end
      end
      HALT: begin
        if (flush_valid) begin
          pc_nxt    = align_pc(flush_pc);
          state_nxt = RUN;
        end else if (resume) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc_out        <= align_pc(RESET_PC);
      wr_ptr        <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_out <= pc_nxt;
      if (push) begin
        wr_ptr <= wr_ptr_inc;
        if (!ras_full) ras_count <= ras_count + 1'b1;
      end else if (pop) begin
        wr_ptr    <= top_ptr;
        ras_count <= ras_count - 1'b1;
      end
      if (set_ovf) ras_overflow  <= 1'b1;
      if (set_unf) ras_underflow <= 1'b1;
    end
  end

  // Return addresses are pure data; a full stack overwrites its oldest slot in place.
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pc_inc;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised fetch program-counter unit for the SPU front end. It generates one fetch-group address per cycle and advances by ISSUE_W per fetch group (dual issue by default). Redirects come from a prioritised set: flush, direct branch, call and return. A small return-address stack (RAS) handles calls and returns, and a run/halt state machine gates fetch. It sits between the branch/commit logic and the instruction memory address port.

Parameters:
ADDR_W, 10, PC width in instruction-address units; all PC arithmetic is modulo 2^ADDR_W.
ISSUE_W, 2, sequential increment and fetch-group alignment; must be a power of 2, at least 1.
RAS_DEPTH, 4, number of return-address stack entries; must be at least 1.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hold the PC; blocks branch/call/ret, does not block flush.
flush_valid  in  1  redirect from commit or exception; highest priority.
flush_pc  in  ADDR_W  flush target.
branch_valid  in  1  taken direct branch this cycle.
branch_call  in  1  qualifies branch_valid as a call: push the return address.
branch_ret  in  1  return: pop the RAS; branch_target is the fallback.
branch_target  in  ADDR_W  branch, call or fallback-return target.
halt_req  in  1  stop fetching (stop instruction).
resume  in  1  leave HALT.
pc_out  out  ADDR_W  current fetch-group address, registered.
pc_valid  out  1  1 when pc_out is a valid fetch request.
ras_count  out  clog2(RAS_DEPTH+1)  number of valid RAS entries.
ras_overflow  out  1  sticky; set when a call pushes onto a full RAS.
ras_underflow  out  1  sticky; set when a return pops an empty RAS.

Behaviour:
- Reset: pc_out=RESET_PC, state=BOOT, pc_valid=0, ras_count=0, ras_overflow=0, ras_underflow=0. Sticky flags clear only on rst.
- States and pc_valid:
  - BOOT: PC holds. Always goes to RUN on the next edge.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0, PC holds.
- Target alignment: all redirect targets have their low log2(ISSUE_W) bits forced to 0. pc_out is always group-aligned.
- RUN next-PC priority, first match wins:
  1. flush_valid: pc<=flush_pc. Ignores stall; RAS unchanged.
  2. halt_req: go to HALT; PC holds.
  3. stall: PC and RAS hold; branch, call and ret are ignored, so the source must keep them asserted until stall=0.
  4. branch_ret:
     - RAS non-empty: pc<=top, pop.
     - RAS empty: pc<=branch_target, set ras_underflow.
     - branch_call in the same cycle is ignored.
  5. branch_valid with branch_call=1: push (pc_out+ISSUE_W) mod 2^ADDR_W, then pc<=branch_target. RAS full: overwrite the oldest entry (circular), count stays at RAS_DEPTH, set ras_overflow.
  6. branch_valid: pc<=branch_target.
  7. Otherwise: pc<=(pc_out+ISSUE_W) mod 2^ADDR_W; wraps from 2^ADDR_W-ISSUE_W to 0.
- HALT:
  - flush_valid: pc<=flush_pc, go to RUN.
  - else resume: go to RUN, continue from the held PC.
  - All other inputs ignored.
- BOOT: all inputs ignored, including flush.
- Latency: a redirect asserted in cycle N appears on pc_out in cycle N+1.
- The RAS is not cleared by flush or halt.
- rst asserted mid-operation immediately forces the reset values above, regardless of state or in-flight redirects.

Test Plan:
1. Reset release, no other stimulus -> pc_valid=0 for one cycle (BOOT), then pc_out sequence 0x000, 0x002, 0x004, 0x006.
2. ADDR_W=10, PC reaches 0x3FE -> next pc_out=0x000; pc_valid stays 1.
3. At pc 0x010, call to 0x100 -> pc 0x100, ras_count=1. Later return -> pc 0x012, ras_count=0. Return on empty RAS with branch_target=0x203 -> pc 0x202, ras_underflow=1.
4. RAS_DEPTH=4, five nested calls from 0x010, 0x020, 0x030, 0x040, 0x050 -> ras_overflow=1, ras_count=4. Four returns give 0x052, 0x042, 0x032, 0x022; the 0x012 entry is lost.
5. stall=1 with branch_valid to 0x080 for 3 cycles -> pc holds. flush_valid to 0x300 during stall -> pc 0x300 next cycle. After stall drops, the branch is taken to 0x080.
6. halt_req at pc 0x040 -> pc_valid=0, pc stays 0x040. Resume -> pc_valid=1, pc 0x040 then 0x042. A second halt ended by flush to 0x1F0 -> RUN at 0x1F0.
